// File: rtl/cpu_pkg.sv
// Shared definitions for the decode-stage register bank.
// Contents:
//   - default data/index widths;
//   - architectural register indices: zero, stack pointer, frame pointer;
//   - reset value loaded into the pointer registers;
//   - state encoding of the init sequencer.
package cpu_pkg;

  localparam int unsigned RF_DATA_W_DEF = 32;
  localparam int unsigned RF_ADDR_W_DEF = 5;
  localparam int unsigned RF_REG_ZERO   = 0;
  localparam int unsigned RF_SP_IDX     = 29;
  localparam int unsigned RF_FP_IDX     = 30;
  localparam int unsigned RF_PTR_INIT   = 65536;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage : cpu_pkg

// File: rtl/rf_init_seq.sv
// Sequential init engine for the register bank.
// After reset it walks every entry, one per cycle, and emits the reset value
// for that entry. It then switches to RUN and raises ready_o.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; restarts the walk at entry 0
//   ready_o      registered; 1 once every entry has been initialised
//   init_we_o    entry init_addr_o is loaded with init_data_o at the next edge
//   init_addr_o  entry currently being initialised
//   init_data_o  PTR_INIT for the stack/frame pointer entries, zero otherwise
module rf_init_seq
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W_DEF,
  parameter int unsigned ADDR_W   = RF_ADDR_W_DEF,
  parameter int unsigned SP_IDX   = RF_SP_IDX,
  parameter int unsigned FP_IDX   = RF_FP_IDX,
  parameter int unsigned PTR_INIT = RF_PTR_INIT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready_o,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic [DATA_W-1:0] init_data_o
);

  localparam logic [ADDR_W-1:0] SP_A     = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] FP_A     = ADDR_W'(FP_IDX);
  localparam logic [DATA_W-1:0] PTR_VAL  = DATA_W'(PTR_INIT);
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};

  rf_state_t       state_q, state_d;
  // One extra bit so the carry out of the last entry marks the end of the walk.
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            ready_q, ready_d;

  // Next-state logic: advance through the entries, then park in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      RF_INIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_d[ADDR_W]) begin
          state_d = RF_RUN;
          ready_d = 1'b1;
        end else begin
          state_d = RF_INIT;
          ready_d = 1'b0;
        end
      end
      RF_RUN: begin
        cnt_d   = cnt_q;
        state_d = RF_RUN;
        ready_d = 1'b1;
      end
      default: begin
        state_d = RF_INIT;
        cnt_d   = CNT_ZERO;
        ready_d = 1'b0;
      end
    endcase
  end

  // State, counter and ready registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= CNT_ZERO;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Init write request and per-entry reset value.
  always_comb begin
    init_we_o   = (state_q == RF_INIT) && !rst;
    init_addr_o = cnt_q[ADDR_W-1:0];
    if ((init_addr_o == SP_A) || (init_addr_o == FP_A)) begin
      init_data_o = PTR_VAL;
    end else begin
      init_data_o = {DATA_W{1'b0}};
    end
  end

  assign ready_o = ready_q;

endmodule : rf_init_seq

// File: rtl/param_register_file.sv
// Parametrised decode-stage register bank.
// Features:
//   - two combinational read ports and one write port;
//   - optional write-to-read bypass;
//   - per-register pending scoreboard for the hazard unit;
//   - sequential init of every entry after reset (see rf_init_seq).
// Register 0 is hardwired to zero. Until Ready rises, writes and reserves are
// ignored and all read outputs are 0.
// Ports:
//   Clock, Reset                 rising-edge clock, synchronous active-high reset
//   ReadRg1/2                    read indices
//   ReadData1/2                  read data, combinational
//   ReadPending1/2               indexed register awaits an outstanding write
//   WriteRg, RegWrite, WriteData write port
//   ReserveRg, Reserve           mark a register pending for an issuing instruction
//   Ready                        init complete
module param_register_file
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W    = RF_DATA_W_DEF,
  parameter int unsigned ADDR_W    = RF_ADDR_W_DEF,
  parameter int unsigned SP_IDX    = RF_SP_IDX,
  parameter int unsigned FP_IDX    = RF_FP_IDX,
  parameter int unsigned PTR_INIT  = RF_PTR_INIT,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] ReadRg1,
  input  logic [ADDR_W-1:0] ReadRg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ReadPending1,
  output logic              ReadPending2,
  input  logic [ADDR_W-1:0] WriteRg,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReserveRg,
  input  logic              Reserve,
  output logic              Ready
);

  localparam int unsigned       DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(RF_REG_ZERO);

  logic              ready_s;
  logic              init_we_s;
  logic [ADDR_W-1:0] init_addr_s;
  logic [DATA_W-1:0] init_data_s;
  logic              wr_en_s;
  logic              rsv_en_s;
  logic              byp1_s;
  logic              byp2_s;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  rf_init_seq #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SP_IDX   (SP_IDX),
    .FP_IDX   (FP_IDX),
    .PTR_INIT (PTR_INIT)
  ) u_init_seq (
    .clk         (Clock),
    .rst         (Reset),
    .ready_o     (ready_s),
    .init_we_o   (init_we_s),
    .init_addr_o (init_addr_s),
    .init_data_o (init_data_s)
  );

  // Architectural write/reserve qualifiers: only in RUN and never to entry 0.
  always_comb begin
    wr_en_s  = ready_s && !Reset && RegWrite && (WriteRg != ZERO_A);
    rsv_en_s = ready_s && !Reset && Reserve && (ReserveRg != ZERO_A);
  end

  // Storage next state: init engine owns the array until Ready.
  always_comb begin
    regs_d = regs_q;
    if (init_we_s) begin
      regs_d[init_addr_s] = init_data_s;
    end else if (wr_en_s) begin
      regs_d[WriteRg] = WriteData;
    end else begin
      regs_d = regs_q;
    end
  end

  // Storage array; no reset, the init engine loads it after reset.
  always_ff @(posedge Clock) begin
    regs_q <= regs_d;
  end

  // Scoreboard next state: a write clears, a reserve sets, and the reserve is
  // applied last so it wins when both hit the same entry.
  always_comb begin
    pend_d = pend_q;
    if (wr_en_s) begin
      pend_d[WriteRg] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (rsv_en_s) begin
      pend_d[ReserveRg] = 1'b1;
    end else begin
      pend_d[0] = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  // Scoreboard register; cleared by reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pend_q <= {DEPTH{1'b0}};
    end else begin
      pend_q <= pend_d;
    end
  end

  // Bypass hits: a qualified write this cycle to the index being read.
  always_comb begin
    byp1_s = BYPASS_EN && wr_en_s && (WriteRg == ReadRg1);
    byp2_s = BYPASS_EN && wr_en_s && (WriteRg == ReadRg2);
  end

  // Read port 1.
  always_comb begin
    ReadData1    = {DATA_W{1'b0}};
    ReadPending1 = 1'b0;
    if (ready_s && (ReadRg1 != ZERO_A)) begin
      ReadData1    = byp1_s ? WriteData : regs_q[ReadRg1];
      ReadPending1 = pend_q[ReadRg1] && !byp1_s;
    end else begin
      ReadData1    = {DATA_W{1'b0}};
      ReadPending1 = 1'b0;
    end
  end

  // Read port 2.
  always_comb begin
    ReadData2    = {DATA_W{1'b0}};
    ReadPending2 = 1'b0;
    if (ready_s && (ReadRg2 != ZERO_A)) begin
      ReadData2    = byp2_s ? WriteData : regs_q[ReadRg2];
      ReadPending2 = pend_q[ReadRg2] && !byp2_s;
    end else begin
      ReadData2    = {DATA_W{1'b0}};
      ReadPending2 = 1'b0;
    end
  end

  assign Ready = ready_s;

endmodule : param_register_file
